// File: rtl/rand_bit_deserializer.sv
// rand_bit_deserializer
// Pulls serial bits from the random engine (bit_req drives its LFSR enable),
// assembles NBITS of them into a word and offers the word on a val/rdy port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; last delivered word is held on 'word'
// COLLECT | bit_req high; every bit_val cycle shifts one bit into word
// DONE    | word complete, word_val high until the sink takes it
module rand_bit_deserializer #(
    parameter int NBITS     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     bit_val,
    input  logic                     bit_in,
    output logic                     bit_req,
    output logic                     word_val,
    input  logic                     word_rdy,
    output logic [NBITS-1:0]         word,
    output logic                     busy,
    output logic [$clog2(NBITS):0]   bit_cnt
);

    localparam int CW = $clog2(NBITS) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  word_q, word_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NBITS-1:0]  shifted;

    // Next word value for one captured bit, in the configured bit order.
    always_comb begin
        shifted = word_q;
        if (MSB_FIRST) begin
            shifted = {word_q[NBITS-2:0], bit_in};
        end else begin
            shifted = {bit_in, word_q[NBITS-1:1]};
        end
    end

    // Next-state, word and count logic; start and bit_val only matter in the states that use them.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    word_d  = '0;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                // The count never passes NBITS because the last capture leaves COLLECT.
                if (bit_val && (cnt_q <= LAST_IDX)) begin
                    word_d = shifted;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (word_rdy) begin
                    if (start) begin
                        state_d = COLLECT;
                        word_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                word_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, word and count registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bit_req  = (state_q == COLLECT);
        word_val = (state_q == DONE);
        busy     = (state_q != IDLE);
        word     = word_q;
        bit_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_rand_bit_deserializer.sv
// Bench for rand_bit_deserializer: one MSB-first and one LSB-first instance share
// the same stimulus and are compared against a queue-based reference model.
module tb_rand_bit_deserializer;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bit_val = 1'b0;
    logic       bit_in = 1'b0;
    logic       word_rdy = 1'b0;

    logic       req_m, val_m, busy_m, req_l, val_l, busy_l;
    logic [7:0] word_m, word_l;
    logic [3:0] cnt_m, cnt_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rand_bit_deserializer #(.NBITS(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .start(start), .bit_val(bit_val), .bit_in(bit_in),
        .bit_req(req_m), .word_val(val_m), .word_rdy(word_rdy), .word(word_m),
        .busy(busy_m), .bit_cnt(cnt_m));

    rand_bit_deserializer #(.NBITS(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .bit_val(bit_val), .bit_in(bit_in),
        .bit_req(req_l), .word_val(val_l), .word_rdy(word_rdy), .word(word_l),
        .busy(busy_l), .bit_cnt(cnt_l));

    // Reference model: which phase of a word we are in, plus the bits received so far.
    localparam int P_IDLE = 0, P_GATHER = 1, P_READY = 2;
    int p_phase = P_IDLE;
    bit bits_q[$];

    function automatic logic [7:0] model_word(input bit msb_first);
        logic [7:0] w;
        int n;
        w = '0;
        n = bits_q.size();
        for (int i = 0; i < n; i++) begin
            if (msb_first) w[n-1-i] = bits_q[i];
            else           w[N-n+i] = bits_q[i];
        end
        return w;
    endfunction

    function automatic logic [2:0] model_flags();
        return {p_phase == P_GATHER, p_phase == P_READY, p_phase != P_IDLE};
    endfunction

    // One clock edge: the model consumes the same inputs the DUTs sample.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            p_phase = P_IDLE;
            bits_q.delete();
        end else if (p_phase == P_IDLE) begin
            if (start) begin
                p_phase = P_GATHER;
                bits_q.delete();
            end
        end else if (p_phase == P_GATHER) begin
            if (bit_val) begin
                bits_q.push_back(bit_in);
                if (bits_q.size() == N) p_phase = P_READY;
            end
        end else if (word_rdy) begin
            if (start) begin
                p_phase = P_GATHER;
                bits_q.delete();
            end else begin
                p_phase = P_IDLE;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; bit_val = 0; bit_in = 0; word_rdy = 0;
    endtask

    // Send a start and eight bits, returning the number of edges until word_val.
    task automatic send_word(input logic [7:0] pattern, output int edges);
        start = 1;
        cyc();
        edges = 1;
        start = 0;
        bit_val = 1;
        for (int i = 7; i >= 0; i--) begin
            bit_in = pattern[i];
            cyc();
            edges++;
        end
        bit_val = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        n_cmp++;
        if ({req_m, val_m, busy_m, word_m, cnt_m} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_msb: got req/val/busy=%b%b%b word=%h cnt=%0d, want all 0",
                     req_m, val_m, busy_m, word_m, cnt_m);
        end
        n_cmp++;
        if ({req_l, val_l, busy_l, word_l, cnt_l} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_lsb: got req/val/busy=%b%b%b word=%h cnt=%0d, want all 0",
                     req_l, val_l, busy_l, word_l, cnt_l);
        end
    endtask

    task automatic test_latency_pattern();
        int edges;
        idle_inputs();
        start = 1;
        cyc();
        start = 0;
        n_cmp++;
        if (req_m !== 1'b1 || cnt_m !== 4'd0) begin
            n_bad++;
            $display("FAIL start_to_req: got req=%b cnt=%0d, want req=1 cnt=0", req_m, cnt_m);
        end
        bit_val = 1;
        edges = 1;
        for (int i = 7; i >= 0; i--) begin
            bit_in = i[0] ? 1'b0 : 1'b1;
            bit_in = ((8'hB2 >> i) & 1) != 0;
            n_cmp++;
            if (val_m !== 1'b0) begin
                n_bad++;
                $display("FAIL early_word_val: got 1 at edge %0d, want 0", edges);
            end
            cyc();
            edges++;
        end
        bit_val = 0;
        n_cmp++;
        if (val_m !== 1'b1 || edges != 9) begin
            n_bad++;
            $display("FAIL word_val_latency: got val=%b after %0d edges, want val=1 after 9", val_m, edges);
        end
        n_cmp++;
        if (word_m !== 8'hB2) begin
            n_bad++;
            $display("FAIL word_msb_first: got %h, want b2", word_m);
        end
        n_cmp++;
        if (word_l !== 8'h4D) begin
            n_bad++;
            $display("FAIL word_lsb_first: got %h, want 4d", word_l);
        end
        cyc();
        n_cmp++;
        if (req_m !== 1'b0 || req_l !== 1'b0 || cnt_m !== 4'd8) begin
            n_bad++;
            $display("FAIL req_after_done: got req=%b/%b cnt=%0d, want 0/0 cnt=8", req_m, req_l, cnt_m);
        end
        word_rdy = 1;
        cyc();
        word_rdy = 0;
        n_cmp++;
        if (busy_m !== 1'b0 || val_m !== 1'b0 || word_m !== 8'hB2) begin
            n_bad++;
            $display("FAIL accept_to_idle: got busy=%b val=%b word=%h, want 0 0 b2", busy_m, val_m, word_m);
        end
    endtask

    task automatic test_bit_val_gap();
        logic [7:0] pat;
        idle_inputs();
        pat = 8'hB2;
        start = 1;
        cyc();
        start = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_val = 1;
            bit_in = pat[i];
            cyc();
            if (i == 4) begin
                bit_val = 0;
                bit_in = 1;
                for (int g = 0; g < 3; g++) begin
                    cyc();
                    n_cmp++;
                    if (cnt_m !== 4'd4 || word_m !== 8'h0B || req_m !== 1'b1) begin
                        n_bad++;
                        $display("FAIL gap_hold: got cnt=%0d word=%h req=%b, want 4 0b 1", cnt_m, word_m, req_m);
                    end
                end
            end
        end
        bit_val = 0;
        n_cmp++;
        if (word_m !== 8'hB2 || word_l !== 8'h4D || val_m !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_word: got %h/%h val=%b, want b2/4d val=1", word_m, word_l, val_m);
        end
    endtask

    task automatic test_hold_done();
        logic [7:0] held;
        held = word_m;
        word_rdy = 0;
        for (int c = 0; c < 5; c++) begin
            start = (c % 2 == 0);
            bit_val = 1;
            bit_in = ~bit_in;
            cyc();
            n_cmp++;
            if (val_m !== 1'b1 || req_m !== 1'b0 || word_m !== held || cnt_m !== 4'd8) begin
                n_bad++;
                $display("FAIL done_hold: got val=%b req=%b word=%h cnt=%0d, want 1 0 %h 8",
                         val_m, req_m, word_m, cnt_m, held);
            end
        end
        idle_inputs();
        word_rdy = 1;
        cyc();
        word_rdy = 0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] pat;
        int edges;
        idle_inputs();
        start = 1;
        cyc();
        start = 0;
        bit_val = 1;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1;
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        bit_val = 0;
        n_cmp++;
        if ({req_m, val_m, busy_m, word_m, cnt_m} !== 15'd0 || word_l !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got req=%b val=%b busy=%b word=%h cnt=%0d, want all 0",
                     req_m, val_m, busy_m, word_m, cnt_m);
        end
        pat = 8'($urandom);
        send_word(pat, edges);
        n_cmp++;
        if (word_m !== model_word(1'b1) || word_l !== model_word(1'b0) || val_m !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_fresh: got %h/%h val=%b, want %h/%h val=1",
                     word_m, word_l, val_m, model_word(1'b1), model_word(1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        start = 1;
        word_rdy = 1;
        cyc();
        word_rdy = 0;
        start = 0;
        n_cmp++;
        if (req_m !== 1'b1 || cnt_m !== 4'd0 || word_m !== 8'd0 || val_m !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_restart: got req=%b cnt=%0d word=%h val=%b, want 1 0 00 0",
                     req_m, cnt_m, word_m, val_m);
        end
        bit_val = 1;
        bit_in = 1;
        edges = 1;
        while (val_m !== 1'b1 && edges < 20) begin
            cyc();
            edges++;
        end
        bit_val = 0;
        n_cmp++;
        if (edges != 9 || word_m !== 8'hFF || word_l !== 8'hFF) begin
            n_bad++;
            $display("FAIL b2b_word: got %h/%h after %0d edges, want ff/ff after 9", word_m, word_l, edges);
        end
        word_rdy = 1;
        cyc();
        word_rdy = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 2) == 0);
            bit_val  = $urandom_range(0, 1);
            bit_in   = $urandom_range(0, 1);
            word_rdy = ($urandom_range(0, 3) != 0);
            cyc();
            n_cmp++;
            if ({req_m, val_m, busy_m} !== model_flags() || cnt_m !== 4'(bits_q.size())
                || word_m !== model_word(1'b1)) begin
                n_bad++;
                $display("FAIL rand_msb c=%0d: got flags=%b cnt=%0d word=%h, want flags=%b cnt=%0d word=%h",
                         c, {req_m, val_m, busy_m}, cnt_m, word_m, model_flags(), bits_q.size(), model_word(1'b1));
            end
            n_cmp++;
            if ({req_l, val_l, busy_l} !== model_flags() || cnt_l !== 4'(bits_q.size())
                || word_l !== model_word(1'b0)) begin
                n_bad++;
                $display("FAIL rand_lsb c=%0d: got flags=%b cnt=%0d word=%h, want flags=%b cnt=%0d word=%h",
                         c, {req_l, val_l, busy_l}, cnt_l, word_l, model_flags(), bits_q.size(), model_word(1'b0));
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2;
        test_reset();
        test_latency_pattern();
        test_bit_val_gap();
        test_hold_done();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
